// File: rtl/nco_pkg.sv
// nco_pkg: shared encodings for the multi-voice NCO.
//   cfg_sel_e : config bus selector values (freq, phase offset, phase reset)
//   state_e   : scan FSM states
package nco_pkg;

    typedef enum logic [1:0] {
        CFG_FREQ = 2'b00,
        CFG_OFFS = 2'b01,
        CFG_PRST = 2'b10,
        CFG_RSVD = 2'b11
    } cfg_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/nco_multi.sv
// nco_multi: time-multiplexed multi-voice NCO. NV phase accumulators share a
// single adder; each sample strobe scans voices 0..NV-1, one voice per clock,
// and emits the updated phase, voice index and accumulator carry.
//
// Optional feature: define NCO_PHASE_OFFSET_EN to add per-voice phase offset
// registers (cfg_sel=01) that are added to out_phs only (acc is unaffected).
//
// Ports:
//   clk       in   1    system clock, posedge
//   reset     in   1    synchronous active-high reset
//   ena       in   1    sample strobe, starts one scan
//   cfg_we    in   1    config write strobe
//   cfg_sel   in   2    00 freq, 01 offset, 10 phase reset, 11 ignored
//   cfg_addr  in   VW   target voice
//   cfg_data  in   DSZ  write data
//   busy      out  1    scan in progress
//   out_valid out  1    out_* valid this cycle
//   out_voice out  VW   voice index of out_phs
//   out_phs   out  DSZ  updated phase (plus offset when enabled)
//   out_wrap  out  1    accumulator carry-out of this update
//   overrun   out  1    pulse: ena arrived while busy
module nco_multi
    import nco_pkg::*;
#(
    parameter  int DSZ = 24,
    parameter  int NV  = 8,
    localparam int VW  = $clog2(NV)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ena,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_sel,
    input  logic [VW-1:0]  cfg_addr,
    input  logic [DSZ-1:0] cfg_data,
    output logic           busy,
    output logic           out_valid,
    output logic [VW-1:0]  out_voice,
    output logic [DSZ-1:0] out_phs,
    output logic           out_wrap,
    output logic           overrun
);

    localparam logic [VW-1:0] LAST   = VW'(NV - 1);
    localparam logic [VW:0]   NV_EXT = (VW + 1)'(NV);

    state_e          state, state_nxt;
    logic [VW-1:0]   idx;
    logic [DSZ-1:0]  acc  [NV];
    logic [DSZ-1:0]  freq [NV];
    logic            scanning;
    logic            addr_ok;
    logic            wr_freq, wr_prst, slot_prst;
    logic [DSZ:0]    sum;
    logic [DSZ-1:0]  phs_base, phs_new;

    assign scanning  = (state == ST_SCAN);
    assign addr_ok   = ({1'b0, cfg_addr} < NV_EXT);
    assign wr_freq   = cfg_we && addr_ok && (cfg_sel == CFG_FREQ);
    assign wr_prst   = cfg_we && addr_ok && (cfg_sel == CFG_PRST);
    // A phase reset landing on the voice being updated overrides the add.
    assign slot_prst = scanning && wr_prst && (cfg_addr == idx);
    assign sum       = {1'b0, acc[idx]} + {1'b0, freq[idx]};
    assign phs_base  = slot_prst ? '0 : sum[DSZ-1:0];

`ifdef NCO_PHASE_OFFSET_EN
    logic [DSZ-1:0] offset [NV];
    logic           wr_offs;
    assign wr_offs = cfg_we && addr_ok && (cfg_sel == CFG_OFFS);
    assign phs_new = phs_base + offset[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NV; i++) offset[VW'(i)] <= '0;
        end else if (wr_offs) begin
            offset[cfg_addr] <= cfg_data;
        end
    end
`else
    assign phs_new = phs_base;
`endif

    always_comb begin
        state_nxt = state;
        busy      = (state == ST_SCAN);
        case (state)
            ST_IDLE: if (ena) state_nxt = ST_SCAN;
            ST_SCAN: if (idx == LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= (scanning && idx != LAST) ? idx + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NV; i++) begin
                acc[VW'(i)]  <= '0;
                freq[VW'(i)] <= '0;
            end
            out_valid <= 1'b0;
            out_voice <= '0;
            out_phs   <= '0;
            out_wrap  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= scanning;
            overrun   <= ena && scanning;
            // freq is read combinationally above, so a same-slot write
            // only affects the voice's next update.
            if (wr_freq) freq[cfg_addr] <= cfg_data;
            if (wr_prst) acc[cfg_addr] <= '0;
            // Scan write comes last; for the same voice it also writes 0
            // when a phase reset coincides, so the order is consistent.
            if (scanning) begin
                acc[idx]  <= phs_base;
                out_voice <= idx;
                out_phs   <= phs_new;
                out_wrap  <= sum[DSZ] & ~slot_prst;
            end
        end
    end

endmodule
